// File: rtl/sum_isqrt_pipe_n.sv
// sum_isqrt_pipe_n: N-channel pipeline computing res = sum of floor(sqrt(x[i])) over enabled channels.
// Each channel runs W/2 digit-by-digit root stages (MSB first). A registered pairwise adder tree
// of $clog2(N) levels follows, then one output register. Latency is W/2+$clog2(N)+1 cycles.
// One argument set is accepted per clock and there is no backpressure.
// A single valid bit travels alongside the data. Data registers load only when their incoming valid is set.
// Optional feature macro: SUM_ISQRT_PIPE_CHAN_OUT_EN adds the per-channel 'roots' output.
module sum_isqrt_pipe_n #(
   parameter int N = 3,
   parameter int W = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     arg_vld,
   input  logic [N*W-1:0]           x,
   input  logic [N-1:0]             chan_en,
   output logic                     res_vld,
   output logic [W/2+$clog2(N)-1:0] res
`ifdef SUM_ISQRT_PIPE_CHAN_OUT_EN
   ,
   output logic [N*(W/2)-1:0]       roots
`endif
);

   localparam int H   = W / 2;
   localparam int LV  = $clog2(N);
   localparam int RW  = H + LV;
   localparam int LAT = H + LV + 1;
   localparam int RB  = H + 2;

   // One digit-by-digit step: bring down two radicand bits, try root*4+1, keep it if it fits.
   function automatic logic [RB+H-1:0] root_step(input logic [RB-1:0] rem_i,
                                                 input logic [H-1:0]  root_i,
                                                 input logic [1:0]    pair_i);
      logic [RB+1:0] cur;
      logic [RB+1:0] trial;
      logic [RB-1:0] rem_n;
      logic [H-1:0]  root_n;
      cur    = {rem_i, pair_i};
      trial  = (RB+2)'({root_i, 2'b01});
      root_n = root_i << 1;
      if (cur >= trial) begin
         rem_n     = RB'(cur - trial);
         root_n[0] = 1'b1;
      end else begin
         rem_n     = RB'(cur);
         root_n[0] = 1'b0;
      end
      return {rem_n, root_n};
   endfunction

   logic [LAT-1:0] vld_q;
   logic [LAT:0]   vin_s;   // vin_s[k] is the valid entering pipeline register stage k

   assign vin_s = {vld_q, arg_vld};

   // valid shift chain; reset discards everything in flight
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_q <= '0;
      end else begin
         vld_q <= {vld_q[LAT-2:0], arg_vld};
      end
   end

   // inter-stage wiring of the root pipeline, index 0 is the module input
   logic [W-1:0]  xin_s    [H+1][N];
   logic [RB-1:0] remin_s  [H+1][N];
   logic [H-1:0]  rootin_s [H+1][N];
   logic          enin_s   [H+1][N];

   for (genvar c = 0; c < N; c++) begin : g_in
      assign xin_s[0][c]    = x[c*W +: W];
      assign remin_s[0][c]  = '0;
      assign rootin_s[0][c] = '0;
      assign enin_s[0][c]   = chan_en[c];
   end

   for (genvar s = 0; s < H; s++) begin : g_stage
      for (genvar c = 0; c < N; c++) begin : g_chan
         logic [RB-1:0]   rem_q;
         logic [H-1:0]    root_q;
         logic            en_q;
         logic [RB+H-1:0] step_s;

         assign step_s = root_step(remin_s[s][c], rootin_s[s][c], xin_s[s][c][W-1 -: 2]);

         // channel mask travels with every accepted set
         always_ff @(posedge clk) begin
            if (vin_s[s]) begin
               en_q <= enin_s[s][c];
            end
         end

         // root/remainder only load for valid, enabled channels
         always_ff @(posedge clk) begin
            if (vin_s[s] && enin_s[s][c]) begin
               rem_q  <= step_s[RB+H-1:H];
               root_q <= step_s[H-1:0];
            end
         end

         assign remin_s[s+1][c]  = rem_q;
         assign rootin_s[s+1][c] = root_q;
         assign enin_s[s+1][c]   = en_q;

         if (s < H - 1) begin : g_x
            logic [W-1:0] x_q;
            // radicand moves up two bits per stage so the next pair is always at the top
            always_ff @(posedge clk) begin
               if (vin_s[s] && enin_s[s][c]) begin
                  x_q <= xin_s[s][c] << 2;
               end
            end
            assign xin_s[s+1][c] = x_q;
         end
      end
   end

   // adder tree, level 0 holds the masked roots
   logic [RW-1:0] tin_s [LV+1][N];

   for (genvar c = 0; c < N; c++) begin : g_leaf
      assign tin_s[0][c] = enin_s[H][c] ? RW'(rootin_s[H][c]) : '0;
   end

   for (genvar l = 0; l < LV; l++) begin : g_lvl
      localparam int CNT = (N + (1 << l) - 1) >> l;
      for (genvar j = 0; j < N; j++) begin : g_node
         if (2*j + 1 < CNT) begin : g_add
            logic [RW-1:0] sum_q;
            // pairwise sum of two operands of the previous level
            always_ff @(posedge clk) begin
               if (vin_s[H+l]) begin
                  sum_q <= tin_s[l][2*j] + tin_s[l][2*j+1];
               end
            end
            assign tin_s[l+1][j] = sum_q;
         end else if (2*j < CNT) begin : g_pass
            logic [RW-1:0] pass_q;
            // odd operand is delayed to stay aligned with its level
            always_ff @(posedge clk) begin
               if (vin_s[H+l]) begin
                  pass_q <= tin_s[l][2*j];
               end
            end
            assign tin_s[l+1][j] = pass_q;
         end
      end
   end

   logic [RW-1:0] res_q;

   // output register, holds the last result between valid pulses
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         res_q <= '0;
      end else if (vin_s[LAT-1]) begin
         res_q <= tin_s[LV][0];
      end
   end

   assign res     = res_q;
   assign res_vld = vin_s[LAT];

`ifdef SUM_ISQRT_PIPE_CHAN_OUT_EN
   logic [H-1:0]   rd_s [LV+1][N];
   logic [N*H-1:0] roots_q;

   for (genvar c = 0; c < N; c++) begin : g_rd_in
      assign rd_s[0][c] = enin_s[H][c] ? rootin_s[H][c] : '0;
   end

   for (genvar l = 0; l < LV; l++) begin : g_rd_lvl
      for (genvar c = 0; c < N; c++) begin : g_rd_chan
         logic [H-1:0] rd_q;
         // delay each channel root through the tree depth
         always_ff @(posedge clk) begin
            if (vin_s[H+l]) begin
               rd_q <= rd_s[l][c];
            end
         end
         assign rd_s[l+1][c] = rd_q;
      end
   end

   // per-channel root output, aligned with res
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         roots_q <= '0;
      end else if (vin_s[LAT-1]) begin
         for (int c = 0; c < N; c++) begin
            roots_q[c*H +: H] <= rd_s[LV][c];
         end
      end
   end

   assign roots = roots_q;
`endif

endmodule

// File: tb/tb_sum_isqrt_pipe_n.sv
// Directed bench for sum_isqrt_pipe_n: table of hand-computed vectors, pipelined scoreboard replay,
// reset-in-flight sequence and two extra parameterisations (N=1/W=8 and N=5/W=16).
module tb_sum_isqrt_pipe_n;

   localparam int LAT_A = 19;
   localparam int LAT_B = 5;
   localparam int LAT_C = 12;

   logic clk = 1'b0;
   logic rst = 1'b0;

   logic        a_vld = 1'b0;
   logic [95:0] a_x   = '0;
   logic [2:0]  a_en  = '0;
   logic        a_rvld;
   logic [17:0] a_res;
   logic        b_vld = 1'b0;
   logic [7:0]  b_x   = '0;
   logic [0:0]  b_en  = '0;
   logic        b_rvld;
   logic [3:0]  b_res;
   logic        c_vld = 1'b0;
   logic [79:0] c_x   = '0;
   logic [4:0]  c_en  = '0;
   logic        c_rvld;
   logic [10:0] c_res;
`ifdef SUM_ISQRT_PIPE_CHAN_OUT_EN
   logic [47:0] a_roots;
   logic [3:0]  b_roots;
   logic [39:0] c_roots;
`endif

   sum_isqrt_pipe_n #(.N(3), .W(32)) dut_a (
      .clk(clk), .rst(rst), .arg_vld(a_vld), .x(a_x), .chan_en(a_en),
      .res_vld(a_rvld), .res(a_res)
`ifdef SUM_ISQRT_PIPE_CHAN_OUT_EN
      , .roots(a_roots)
`endif
   );

   sum_isqrt_pipe_n #(.N(1), .W(8)) dut_b (
      .clk(clk), .rst(rst), .arg_vld(b_vld), .x(b_x), .chan_en(b_en),
      .res_vld(b_rvld), .res(b_res)
`ifdef SUM_ISQRT_PIPE_CHAN_OUT_EN
      , .roots(b_roots)
`endif
   );

   sum_isqrt_pipe_n #(.N(5), .W(16)) dut_c (
      .clk(clk), .rst(rst), .arg_vld(c_vld), .x(c_x), .chan_en(c_en),
      .res_vld(c_rvld), .res(c_res)
`ifdef SUM_ISQRT_PIPE_CHAN_OUT_EN
      , .roots(c_roots)
`endif
   );

   always #5 clk = ~clk;

   int cyc    = 0;
   int checks = 0;
   int errors = 0;
   bit mon_en = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [95:0] x;
      logic [2:0]  en;
      logic [17:0] exp;
   } vec_t;

   typedef struct {
      logic [17:0] val;
      int          cyc;
   } exp_t;

   vec_t tbl[12];
   exp_t expq[$];
   exp_t mon_e;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic [31:0] x0, input logic [31:0] x1, input logic [31:0] x2,
                               input logic [2:0] en, input logic [17:0] exp);
      vec_t v;
      v.x   = {x2, x1, x0};
      v.en  = en;
      v.exp = exp;
      return v;
   endfunction

   // reference root by bitwise search with a square compare
   function automatic logic [31:0] isqrt_m(input logic [31:0] v);
      logic [31:0] r;
      logic [63:0] c64;
      r = '0;
      for (int b = 15; b >= 0; b--) begin
         c64 = 64'(r | (32'd1 << b));
         if (c64 * c64 <= 64'(v)) r = 32'(c64);
      end
      return r;
   endfunction

   function automatic logic [17:0] model(input logic [95:0] xv, input logic [2:0] ev);
      logic [31:0] s;
      s = '0;
      for (int c = 0; c < 3; c++) begin
         if (ev[c]) s = s + isqrt_m(xv[c*32 +: 32]);
      end
      return 18'(s);
   endfunction

   function automatic logic [31:0] rnd_x();
      case ($urandom_range(0, 5))
         0:       return 32'd0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'($urandom_range(0, 300));
         default: return $urandom();
      endcase
   endfunction

   // pulse one DUT's arg_vld for a cycle and wait (bounded) for its res_vld
   task automatic fire(input int which, output int lat, output logic [31:0] val);
      bit found;
      found = 1'b0;
      val   = '0;
      case (which)
         0:       a_vld = 1'b1;
         1:       b_vld = 1'b1;
         default: c_vld = 1'b1;
      endcase
      @(negedge clk);
      a_vld = 1'b0;
      b_vld = 1'b0;
      c_vld = 1'b0;
      lat = 1;
      while (!found && lat <= 40) begin
         case (which)
            0:       if (a_rvld) begin found = 1'b1; val = 32'(a_res); end
            1:       if (b_rvld) begin found = 1'b1; val = 32'(b_res); end
            default: if (c_rvld) begin found = 1'b1; val = 32'(c_res); end
         endcase
         if (!found) begin
            lat++;
            @(negedge clk);
         end
      end
   endtask

   // one cycle of streaming stimulus on the main DUT, expectation queued with its arrival cycle
   task automatic send(input logic v, input logic [95:0] xv, input logic [2:0] ev, input logic [17:0] exp);
      exp_t e;
      a_vld = v;
      a_x   = xv;
      a_en  = ev;
      if (v) begin
         e.val = exp;
         e.cyc = cyc + LAT_A;
         expq.push_back(e);
      end
      @(negedge clk);
   endtask

   // scoreboard for the main DUT: value, arrival cycle, no spurious or missing results
   always @(negedge clk) begin
      if (mon_en) begin
         if (a_rvld) begin
            if (expq.size() == 0) begin
               chk("stream_unexpected_vld", 64'(a_rvld), 64'd0);
            end else begin
               mon_e = expq.pop_front();
               chk("stream_res", 64'(a_res), 64'(mon_e.val));
               chk("stream_cyc", 64'(cyc), 64'(mon_e.cyc));
            end
         end else if (expq.size() != 0 && expq[0].cyc <= cyc) begin
            mon_e = expq.pop_front();
            chk("stream_missing_vld", 64'(a_rvld), 64'd1);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          lat;
      logic [31:0] val;
      logic [17:0] last;
      logic [95:0] rx;
      logic [2:0]  ren;
      int          nvld;
      bit          res_zero;

      tbl[0]  = mk(32'd16, 32'd25, 32'd36, 3'b111, 18'd15);
      tbl[1]  = mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b111, 18'd196605);
      tbl[2]  = mk(32'd2, 32'd3, 32'd8, 3'b101, 18'd3);
      tbl[3]  = mk(32'd0, 32'd0, 32'd0, 3'b111, 18'd0);
      tbl[4]  = mk(32'd100, 32'd200, 32'd300, 3'b000, 18'd0);
      tbl[5]  = mk(32'd99, 32'd1, 32'd1000000, 3'b111, 18'd1010);
      tbl[6]  = mk(32'd15, 32'd16, 32'd17, 3'b010, 18'd4);
      tbl[7]  = mk(32'hFFFF_FFFF, 32'd12345, 32'd12345, 3'b001, 18'd65535);
      tbl[8]  = mk(32'd65535, 32'd65536, 32'd4294836225, 3'b111, 18'd66046);
      tbl[9]  = mk(32'd4294836224, 32'd3, 32'd4, 3'b110, 18'd3);
      tbl[10] = mk(32'd1, 32'd2, 32'd3, 3'b011, 18'd2);
      tbl[11] = mk(32'd24, 32'd35, 32'd48, 3'b111, 18'd15);

      // reset state
      #2;
      chk("rst_a_res", 64'(a_res), 64'd0);
      chk("rst_a_vld", 64'(a_rvld), 64'd0);
      chk("rst_b_res", 64'(b_res), 64'd0);
      chk("rst_c_vld", 64'(c_rvld), 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;

      // table vectors one at a time: value and exact latency
      for (int i = 0; i < 12; i++) begin
         a_x  = tbl[i].x;
         a_en = tbl[i].en;
         fire(0, lat, val);
         chk($sformatf("tbl%0d_res", i), 64'(val), 64'(tbl[i].exp));
         chk($sformatf("tbl%0d_lat", i), 64'(lat), 64'(LAT_A));
      end

      // streaming: table back-to-back, random back-to-back, random gaps
      @(negedge clk);
      mon_en = 1'b1;
      for (int i = 0; i < 12; i++) send(1'b1, tbl[i].x, tbl[i].en, tbl[i].exp);
      last = '0;
      for (int i = 0; i < 50; i++) begin
         rx   = {rnd_x(), rnd_x(), rnd_x()};
         ren  = 3'($urandom_range(0, 7));
         last = model(rx, ren);
         send(1'b1, rx, ren, last);
      end
      for (int i = 0; i < 40; i++) begin
         rx  = {rnd_x(), rnd_x(), rnd_x()};
         ren = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 1) == 1) begin
            last = model(rx, ren);
            send(1'b1, rx, ren, last);
         end else begin
            send(1'b0, rx, ren, 18'd0);
         end
      end
      for (int i = 0; i < LAT_A + 4; i++) send(1'b0, {rnd_x(), rnd_x(), rnd_x()}, 3'b111, 18'd0);
      chk("stream_drained", 64'(expq.size()), 64'd0);
      // result holds while idle
      for (int i = 0; i < 4; i++) begin
         chk("hold_res", 64'(a_res), 64'(last));
         chk("hold_vld", 64'(a_rvld), 64'd0);
         @(negedge clk);
      end
      mon_en = 1'b0;

      // reset with five sets in flight
      for (int i = 0; i < 5; i++) begin
         a_vld = 1'b1;
         a_x   = tbl[1].x;
         a_en  = 3'b111;
         @(negedge clk);
      end
      a_vld = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("midrst_res", 64'(a_res), 64'd0);
      chk("midrst_vld", 64'(a_rvld), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      nvld     = 0;
      res_zero = 1'b1;
      for (int i = 0; i < 30; i++) begin
         if (a_rvld) nvld++;
         if (a_res != 18'd0) res_zero = 1'b0;
         @(negedge clk);
      end
      chk("flushed_vld_count", 64'(nvld), 64'd0);
      chk("flushed_res_zero", 64'(res_zero), 64'd1);
      a_x  = tbl[0].x;
      a_en = tbl[0].en;
      fire(0, lat, val);
      chk("post_rst_res", 64'(val), 64'd15);
      chk("post_rst_lat", 64'(lat), 64'(LAT_A));

      // N=1, W=8
      b_x = 8'd255; b_en = 1'b1;
      fire(1, lat, val);
      chk("n1_max_res", 64'(val), 64'd15);
      chk("n1_max_lat", 64'(lat), 64'(LAT_B));
      b_x = 8'd16;
      fire(1, lat, val);
      chk("n1_16_res", 64'(val), 64'd4);
      b_x = 8'd0;
      fire(1, lat, val);
      chk("n1_zero_res", 64'(val), 64'd0);
      b_x = 8'd200; b_en = 1'b0;
      fire(1, lat, val);
      chk("n1_masked_res", 64'(val), 64'd0);

      // N=5, W=16
      c_x = {5{16'hFFFF}}; c_en = 5'b11111;
      fire(2, lat, val);
      chk("n5_max_res", 64'(val), 64'd1275);
      chk("n5_max_lat", 64'(lat), 64'(LAT_C));
      c_x = {16'd16, 16'd9, 16'd4, 16'd1, 16'd0}; c_en = 5'b10101;
      fire(2, lat, val);
      chk("n5_mask_res", 64'(val), 64'd6);
      c_en = 5'b11111;
      fire(2, lat, val);
      chk("n5_all_res", 64'(val), 64'd10);

`ifdef SUM_ISQRT_PIPE_CHAN_OUT_EN
      a_x  = {32'd36, 32'd25, 32'd16};
      a_en = 3'b110;
      fire(0, lat, val);
      chk("roots_res", 64'(val), 64'd11);
      chk("roots_ch0", 64'(a_roots[15:0]), 64'd0);
      chk("roots_ch1", 64'(a_roots[31:16]), 64'd5);
      chk("roots_ch2", 64'(a_roots[47:32]), 64'd6);
`endif

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
